// File: rtl/pipe_ctrl.sv
// Decode-stage issue controller: register scoreboard, RAW/WAW and mul/div
// structural hazard detection, stall/flush/issue generation, drain FSM, stall counter.
module pipe_ctrl #(
   parameter int MULDIV_LAT = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_wr_rd,
   input  logic             id_muldiv,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic             ex_redirect,
   input  logic             drain_req,
   output logic             issue,
   output logic             stall,
   output logic             flush,
   output logic             drain_done,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] pending, pend_eff, pend_nxt;
   logic [3:0]  mulcnt, mulcnt_nxt;
   logic        raw, waw, mdh, hz, run;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // RF writes on the falling edge, so a same-cycle write-back already clears the hazard
   always_comb begin
      pend_eff = pending;
      if (wb_valid) pend_eff[wb_rd] = 1'b0;
      pend_eff[0] = 1'b0;
   end

   always_comb begin
      raw = (id_use_rs1 & pend_eff[id_rs1]) | (id_use_rs2 & pend_eff[id_rs2]);
      waw = id_wr_rd & pend_eff[id_rd];
      mdh = id_muldiv & (mulcnt != 4'd0);
      hz  = id_valid & (raw | waw | mdh);
   end

   assign flush = ex_redirect;
   assign issue = id_valid & ~hz & ~ex_redirect & run;
   assign stall = id_valid & ~ex_redirect & (hz | ~run);

   always_comb begin
      pend_nxt = pend_eff;
      if (issue && id_wr_rd && (id_rd != 5'd0)) pend_nxt[id_rd] = 1'b1;
      if (issue && id_muldiv)       mulcnt_nxt = 4'(MULDIV_LAT);
      else if (mulcnt != 4'd0)      mulcnt_nxt = mulcnt - 4'd1;
      else                          mulcnt_nxt = mulcnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending   <= '0;
         mulcnt    <= '0;
         stall_cnt <= '0;
      end else begin
         pending <= pend_nxt;
         mulcnt  <= mulcnt_nxt;
         if (stall) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   // Dropping drain_req mid-drain takes priority over completing it
   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:   if (drain_req) state_nxt = DRAIN;
         DRAIN: begin
            if (!drain_req)                                            state_nxt = RUN;
            else if ((pending == '0) && (mulcnt == 4'd0) && !issue)    state_nxt = DONE;
         end
         DONE:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      run        = (state == RUN);
      drain_done = (state == DONE);
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
   logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wr_rd = 1'b0, id_muldiv = 1'b0;
   logic             wb_valid = 1'b0, ex_redirect = 1'b0, drain_req = 1'b0;
   logic             issue, stall, flush, drain_done;
   logic [CNT_W-1:0] stall_cnt;

   pipe_ctrl #(.MULDIV_LAT(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr_rd(id_wr_rd),
      .id_muldiv(id_muldiv), .wb_valid(wb_valid), .wb_rd(wb_rd), .ex_redirect(ex_redirect),
      .drain_req(drain_req), .issue(issue), .stall(stall), .flush(flush),
      .drain_done(drain_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit             iss, stl, fl, dn;
      logic [CNT_W-1:0] cnt;
      int             tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, passes = 0, tagn = 0;
   bit   rst_v = 1'b0;
   logic [CNT_W-1:0] ecnt = '0;

   task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s vec%0d: got %0d expected %0d", nm, tag, act, req);
   endtask

   // One cycle of stimulus; flush is expected to follow ex_redirect directly
   task automatic vec(input bit v, input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                      input bit u2, input logic [4:0] rd, input bit wr, input bit md,
                      input bit wbv, input logic [4:0] wbrd, input bit redir, input bit dq,
                      input bit eiss, input bit estl, input bit edone);
      exp_t e;
      @(posedge clk); #1;
      rst = rst_v;
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_wr_rd = wr; id_muldiv = md; wb_valid = wbv; wb_rd = wbrd;
      ex_redirect = redir; drain_req = dq;
      if (!rst_v) ecnt = '0;
      e.iss = eiss; e.stl = estl; e.fl = redir; e.dn = edone; e.cnt = ecnt; e.tag = tagn++;
      exp_q.push_back(e);
      if (rst_v && estl) ecnt = (ecnt == '1) ? ecnt : ecnt + 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue",      e.tag, 32'(issue),      32'(e.iss));
            chk("stall",      e.tag, 32'(stall),      32'(e.stl));
            chk("flush",      e.tag, 32'(flush),      32'(e.fl));
            chk("drain_done", e.tag, 32'(drain_done), 32'(e.dn));
            chk("stall_cnt",  e.tag, 32'(stall_cnt),  32'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      //   v  rs1 u1 rs2 u2 rd wr md wbv wbrd rdr dq   iss stl dn
      rst_v = 1'b0;
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);   // reset state
      rst_v = 1'b1;
      // RAW on x5, cleared by same-cycle write-back
      vec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,   1, 0, 0);
      vec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 1, 0);
      vec(1, 5, 1, 0, 0, 6, 1, 0, 1, 5, 0, 0,   1, 0, 0);
      vec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);
      // WAW on x7 and set-wins over same-cycle clear
      vec(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,   1, 0, 0);
      vec(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 1, 0);
      vec(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0, 0,   1, 0, 0);
      vec(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0);
      vec(1, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0,   1, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,   0, 0, 0);
      // x0 never hazards
      vec(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0);
      vec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);
      // mul/div structural hazard: mul at cycle 0, independent op at 1, mul stalls 2..8, issues at 9
      vec(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0,  1, 0, 0);
      vec(1, 1, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0,  1, 0, 0);
      for (int i = 0; i < 7; i++)
         vec(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      vec(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0,  1, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0,  0, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0,  0, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0,  0, 0, 0);
      // redirect beats a RAW stall and leaves the scoreboard untouched
      vec(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0,  1, 0, 0);
      vec(1, 0, 0, 13, 1, 14, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      vec(1, 0, 0, 13, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      vec(1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0,  0, 0, 0);
      // drain with x3 outstanding
      vec(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,   1, 0, 0);
      vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0);
      vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1,   0, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0);
      vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1);
      vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);
      // drain abandoned: no pulse, back to RUN
      vec(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1,   1, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
      vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);
      // async reset in the middle of a drain with x4 pending
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0);
      vec(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0);
      rst_v = 1'b0;
      vec(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0);
      rst_v = 1'b1;
      vec(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);
      // stall counter saturation (4-bit counter, 17 stalls)
      vec(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0,   1, 0, 0);
      for (int i = 0; i < 17; i++)
         vec(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      vec(1, 8, 1, 0, 0, 0, 0, 0, 1, 8, 0, 0,   1, 0, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain_queue: %0d expectations left, 0 required", exp_q.size());
      end
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Scoreboard-based issue controller for the decode stage of the 64-bit RISC-V pipeline. It tracks pending register-file writes and detects RAW/WAW hazards and the multi-cycle mul/div structural hazard. It generates stall/flush controls for IF/ID and the issue strobe into EX. It also drains the pipeline on request (fence/ecall) and counts stall cycles.

Parameters:
MULDIV_LAT, 8, cycles the mul/div unit is busy after a mul/div issue (1..15)
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
id_valid  input  1  decode stage holds a valid instruction
id_rs1  input  5  source register 1
id_rs2  input  5  source register 2
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_rd  input  5  destination register
id_wr_rd  input  1  instruction writes rd (0 for store/branch)
id_muldiv  input  1  instruction is mul/div
wb_valid  input  1  write-back occurring this cycle
wb_rd  input  5  write-back destination
ex_redirect  input  1  taken branch/jump resolved in EX this cycle
drain_req  input  1  request to drain (level, held until drain_done)
issue  output  1  ID instruction advances to EX this cycle (combinational)
stall  output  1  hold PC and IF/ID register (combinational)
flush  output  1  invalidate IF/ID contents (combinational)
drain_done  output  1  one-cycle pulse (registered), pipeline empty
stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- State: pending[31:0] (one bit per register), mulcnt (4 bits), FSM {RUN, DRAIN, DONE}, stall_cnt.
- Reset (rst=0, asynchronous): pending=0, mulcnt=0, FSM=RUN, drain_done=0, stall_cnt=0. Reset mid-drain abandons the drain.
- Effective pending: pend_eff = pending with bit wb_rd cleared when wb_valid. RF writes back on the falling edge, so a same-cycle write-back is visible to decode. Register x0 is never pending; reads or writes of x0 never hazard.
- Hazards (all evaluated only when id_valid):
  - raw = (id_use_rs1 & pend_eff[id_rs1]) | (id_use_rs2 & pend_eff[id_rs2])
  - waw = id_wr_rd & pend_eff[id_rd]
  - mdh = id_muldiv & (mulcnt != 0)
  - hz = raw | waw | mdh
- Outputs:
  - flush = ex_redirect
  - issue = id_valid & ~hz & ~ex_redirect & (FSM==RUN)
  - stall = id_valid & ~ex_redirect & (hz | FSM!=RUN)
  - Redirect has priority: flush=1 forces issue=0 and stall=0.
- Scoreboard update each edge: pending <= pend_eff, then set bit id_rd if issue & id_wr_rd & id_rd!=0. Set wins over a same-cycle clear of the same register.
- mulcnt: loads MULDIV_LAT on issue & id_muldiv; otherwise decrements if nonzero. A mul/div may issue in the cycle mulcnt reaches 0.
- FSM transitions:
  - RUN -> DRAIN when drain_req=1. The instruction in ID at that edge may still issue that cycle; issue is blocked from the next cycle.
  - DRAIN -> DONE when pending==0, mulcnt==0 and no issue this cycle.
  - DONE: drain_done=1 for exactly one cycle, then -> RUN.
  - If drain_req deasserts in DRAIN, return to RUN without a drain_done pulse.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- wb_valid with wb_rd=0 is a no-op. A write-back to a non-pending register is a no-op.

Test Plan:
- RAW: issue add x5 (id_wr_rd=1); next cycle id_use_rs1=1, id_rs1=5 with no WB -> stall=1, issue=0, stall_cnt=1. Then assert wb_valid, wb_rd=5 -> issue=1 in that same cycle, pending[5]=0.
- WAW plus set-wins: with pending[7]=1, an instruction with id_rd=7 stalls. In the cycle wb_rd=7 it issues, and pending[7]=1 after the edge.
- Mul/div with MULDIV_LAT=8: issue mul at cycle 0. A second mul stalls for cycles 1-8 and issues at cycle 9. A non-mul independent instruction issues at cycle 1.
- Redirect: ex_redirect=1 while ID holds a RAW-hazard instruction -> flush=1, stall=0, issue=0, pending unchanged, stall_cnt unchanged.
- Drain: pending[3]=1, drain_req=1 -> FSM DRAIN with stall=1 on valid IDs. After wb_rd=3 -> DONE, drain_done pulses one cycle, then RUN, and issue resumes.
- Async reset asserted mid-DRAIN with pending!=0 -> immediately pending=0, drain_done=0, stall_cnt=0. After release, a previously hazarding instruction issues.
